// File: rtl/sipo_pkg.sv
// sipo_pkg: receiver states, serial line levels and counter sizing shared by sipo_rx.
package sipo_pkg;
    typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, WAIT_HIGH} state_t;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT = 1'b1;
    function automatic int clog2(input int v);
        int r;
        r = 1;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/sipo_out_reg.sv
// sipo_out_reg: one-word valid/ready holding register; a word arriving while the slot is full is dropped and flagged.
module sipo_out_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             word_done,
    input  logic [WIDTH-1:0] word,
    input  logic             data_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             overrun
);
    logic hs, load, drop;
    assign hs = data_valid & data_ready;
    assign load = word_done & (~data_valid | hs);
    assign drop = word_done & ~load;
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            data_out <= '0;
            data_valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            data_out <= load ? word : data_out;
            data_valid <= load | (data_valid & ~hs);
            overrun <= drop | (overrun & ~hs);
        end
endmodule

// File: rtl/sipo_rx.sv
// sipo_rx: strobe-sampled serial receiver (start, WIDTH data, stop) with framing error detection.
// Define SIPO_RX_PARITY_EN to add an even parity bit before the stop bit and the parity_err output.
module sipo_rx import sipo_pkg::*; #(
    parameter int WIDTH = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             bit_en,
    input  logic             serial_in,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             overrun,
    output logic             frame_err,
    output logic             busy
`ifdef SIPO_RX_PARITY_EN
    ,
    output logic             parity_err
`endif
);
    localparam int CW = clog2(WIDTH);
`ifdef SIPO_RX_PARITY_EN
    localparam state_t AFTER_DATA = PARITY;
    logic par, par_n, perr_n;
`else
    localparam state_t AFTER_DATA = STOP;
`endif
    state_t state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [WIDTH-1:0] sh, sh_n;
    logic par_ok, word_done, ferr_n;
`ifdef SIPO_RX_PARITY_EN
    assign par_ok = ~(^sh ^ par);
`else
    assign par_ok = 1'b1;
`endif
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        sh_n = sh;
        word_done = 1'b0;
        ferr_n = 1'b0;
`ifdef SIPO_RX_PARITY_EN
        par_n = par;
        perr_n = 1'b0;
`endif
        if (bit_en)
            case (state)
                IDLE: if (serial_in == START_BIT) begin
                    state_n = DATA;
                    cnt_n = '0;
                end
                DATA: begin
                    sh_n = MSB_FIRST ? {sh[WIDTH-2:0], serial_in} : {serial_in, sh[WIDTH-1:1]};
                    cnt_n = cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) state_n = AFTER_DATA;
                end
`ifdef SIPO_RX_PARITY_EN
                PARITY: begin
                    par_n = serial_in;
                    state_n = STOP;
                end
`endif
                STOP: if (serial_in == STOP_BIT) begin
                    state_n = IDLE;
                    word_done = par_ok;
`ifdef SIPO_RX_PARITY_EN
                    perr_n = ~par_ok;
`endif
                end else begin
                    ferr_n = 1'b1;
                    state_n = WAIT_HIGH;
                end
                // a line held low after a bad stop must not look like a new start bit
                WAIT_HIGH: state_n = (serial_in == STOP_BIT) ? IDLE : WAIT_HIGH;
                default: state_n = IDLE;
            endcase
    end
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            sh <= '0;
            frame_err <= 1'b0;
`ifdef SIPO_RX_PARITY_EN
            par <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            sh <= sh_n;
            frame_err <= ferr_n;
`ifdef SIPO_RX_PARITY_EN
            par <= par_n;
            parity_err <= perr_n;
`endif
        end
    assign busy = state != IDLE;
    sipo_out_reg #(.WIDTH(WIDTH)) u_out (
        .clk(clk),
        .reset(reset),
        .word_done(word_done),
        .word(sh),
        .data_ready(data_ready),
        .data_out(data_out),
        .data_valid(data_valid),
        .overrun(overrun)
    );
endmodule

// File: tb/tb_sipo_rx.sv
// tb_sipo_rx: two receivers (MSB-first and LSB-first) on one line, checked every cycle against a frame-level model.
module tb_sipo_rx;
    logic clk = 1'b0, reset = 1'b1, bit_en = 1'b0, serial_in = 1'b1, data_ready = 1'b0;
    logic [3:0] d0, d1;
    logic v0, v1, o0, o1, f0, f1, b0, b1;
`ifdef SIPO_RX_PARITY_EN
    logic p0, p1, e_perr;
`endif
    int total = 0, bad = 0, ferr_seen = 0;
    typedef struct {logic b; logic bz; logic [1:0] ev; logic [3:0] w;} sbit_t;
    sbit_t q[$];
    logic [3:0] e_data = '0;
    logic e_valid = 1'b0, e_ovr = 1'b0, e_ferr = 1'b0, e_busy = 1'b0;
    always #5 clk = ~clk;
    sipo_rx #(.WIDTH(4), .MSB_FIRST(1'b1)) u0 (
        .clk(clk), .reset(reset), .bit_en(bit_en), .serial_in(serial_in),
        .data_out(d0), .data_valid(v0), .data_ready(data_ready),
        .overrun(o0), .frame_err(f0), .busy(b0)
`ifdef SIPO_RX_PARITY_EN
        , .parity_err(p0)
`endif
    );
    sipo_rx #(.WIDTH(4), .MSB_FIRST(1'b0)) u1 (
        .clk(clk), .reset(reset), .bit_en(bit_en), .serial_in(serial_in),
        .data_out(d1), .data_valid(v1), .data_ready(data_ready),
        .overrun(o1), .frame_err(f1), .busy(b1)
`ifdef SIPO_RX_PARITY_EN
        , .parity_err(p1)
`endif
    );
    function automatic logic [3:0] rev4(input logic [3:0] x);
        return {x[0], x[1], x[2], x[3]};
    endfunction
    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask
    task automatic check_all();
        chk("u0_data", {4'h0, d0}, {4'h0, e_data});
        chk("u1_data", {4'h0, d1}, {4'h0, rev4(e_data)});
        chk("u0_valid", 8'(v0), 8'(e_valid));
        chk("u1_valid", 8'(v1), 8'(e_valid));
        chk("u0_overrun", 8'(o0), 8'(e_ovr));
        chk("u1_overrun", 8'(o1), 8'(e_ovr));
        chk("u0_frame_err", 8'(f0), 8'(e_ferr));
        chk("u1_frame_err", 8'(f1), 8'(e_ferr));
        chk("u0_busy", 8'(b0), 8'(e_busy));
        chk("u1_busy", 8'(b1), 8'(e_busy));
`ifdef SIPO_RX_PARITY_EN
        chk("u0_parity_err", 8'(p0), 8'(e_perr));
        chk("u1_parity_err", 8'(p1), 8'(e_perr));
`endif
    endtask
    task automatic push(input logic b, input logic bz, input logic [1:0] ev, input logic [3:0] w);
        sbit_t s;
        s.b = b; s.bz = bz; s.ev = ev; s.w = w;
        q.push_back(s);
    endtask
    // ev: 1 = good stop delivering w, 2 = bad stop, 3 = parity mismatch with good stop
    task automatic push_frame(input logic [3:0] w, input bit stop_ok, input bit par_bad, input int lows);
        push(1'b0, 1'b1, 2'd0, 4'h0);
        for (int i = 3; i >= 0; i--) push(w[i], 1'b1, 2'd0, 4'h0);
`ifdef SIPO_RX_PARITY_EN
        push(^w ^ par_bad, 1'b1, 2'd0, 4'h0);
        if (stop_ok) push(1'b1, 1'b0, par_bad ? 2'd3 : 2'd1, w);
`else
        if (stop_ok) push(1'b1, 1'b0, 2'd1, w);
`endif
        else begin
            push(1'b0, 1'b1, 2'd2, 4'h0);
            repeat (lows) push(1'b0, 1'b1, 2'd0, 4'h0);
            push(1'b1, 1'b0, 2'd0, 4'h0);
        end
    endtask
    task automatic model_reset();
        e_data = '0; e_valid = 1'b0; e_ovr = 1'b0; e_ferr = 1'b0; e_busy = 1'b0;
`ifdef SIPO_RX_PARITY_EN
        e_perr = 1'b0;
`endif
    endtask
    task automatic cyc(input logic be, input logic rdy);
        sbit_t cur;
        cur.b = 1'b1; cur.bz = 1'b0; cur.ev = 2'd0; cur.w = 4'h0;
        if (be && q.size() > 0) cur = q.pop_front();
        bit_en = be;
        data_ready = rdy;
        serial_in = be ? cur.b : 1'($urandom);
        @(posedge clk);
        e_ferr = be && cur.ev == 2'd2;
`ifdef SIPO_RX_PARITY_EN
        e_perr = be && cur.ev == 2'd3;
`endif
        if (be) e_busy = cur.bz;
        if (e_valid && rdy) begin
            e_valid = 1'b0;
            e_ovr = 1'b0;
        end
        if (be && cur.ev == 2'd1) begin
            if (!e_valid) begin
                e_valid = 1'b1;
                e_data = cur.w;
            end else e_ovr = 1'b1;
        end
        #1;
        if (f0) ferr_seen++;
        check_all();
    endtask
    task automatic run(input int period, input logic rdy);
        int n = 0;
        while (q.size() > 0 && n < 5000) begin
            repeat (period - 1) cyc(1'b0, rdy);
            cyc(1'b1, rdy);
            n++;
        end
        chk("run_budget", 8'(q.size()), 8'd0);
    endtask
    task automatic do_reset();
        #2 reset = 1'b1;
        q.delete();
        model_reset();
        #1;
        check_all();
        chk("rst_busy", 8'(b0), 8'd0);
        chk("rst_data", {4'h0, d0}, 8'h00);
        #2 reset = 1'b0;
    endtask
    initial begin
        model_reset();
        #3;
        check_all();
        chk("por_valid", 8'(v0), 8'd0);
        #4 reset = 1'b0;
        push_frame(4'b1001, 1'b1, 1'b0, 0);
        repeat (5) cyc(1'b1, 1'b1);
        chk("t1_valid_early", 8'(v0), 8'd0);
        cyc(1'b1, 1'b1);
        chk("t1_valid", 8'(v0), 8'd1);
        chk("t1_data", {4'h0, d0}, 8'h09);
        chk("t1_overrun", 8'(o0), 8'd0);
        cyc(1'b1, 1'b1);
        chk("t1_valid_drop", 8'(v0), 8'd0);
        push_frame(4'b0011, 1'b1, 1'b0, 0);
        run(1, 1'b1);
        chk("t2_lsb_data", {4'h0, d1}, 8'h0c);
        chk("t2_lsb_valid", 8'(v1), 8'd1);
        cyc(1'b1, 1'b1);
        push_frame(4'b1001, 1'b1, 1'b0, 0);
        push_frame(4'b1100, 1'b1, 1'b0, 0);
        run(1, 1'b0);
        chk("t3_hold_data", {4'h0, d0}, 8'h09);
        chk("t3_overrun", 8'(o0), 8'd1);
        cyc(1'b1, 1'b1);
        chk("t3_valid_clr", 8'(v0), 8'd0);
        chk("t3_overrun_clr", 8'(o0), 8'd0);
        chk("t3_data_kept", {4'h0, d0}, 8'h09);
        ferr_seen = 0;
        push_frame(4'b1111, 1'b0, 1'b0, 2);
        repeat (6) cyc(1'b1, 1'b1);
        chk("t4_ferr", 8'(f0), 8'd1);
        cyc(1'b1, 1'b1);
        chk("t4_wait_busy", 8'(b0), 8'd1);
        run(1, 1'b1);
        chk("t4_ferr_once", 8'(ferr_seen), 8'd1);
        chk("t4_idle", 8'(b0), 8'd0);
        chk("t4_no_valid", 8'(v0), 8'd0);
        push_frame(4'b0110, 1'b1, 1'b0, 0);
        run(1, 1'b1);
        chk("t4_recover", {4'h0, d0}, 8'h06);
        push_frame(4'b1010, 1'b1, 1'b0, 0);
        repeat (3) begin
            repeat (3) cyc(1'b0, 1'b1);
            cyc(1'b1, 1'b1);
        end
        chk("t5_busy_mid", 8'(b0), 8'd1);
        do_reset();
        push_frame(4'b0101, 1'b1, 1'b0, 0);
        run(4, 1'b1);
        chk("t5_after_rst", {4'h0, d0}, 8'h05);
        chk("t5_after_rst_lsb", {4'h0, d1}, 8'h0a);
`ifdef SIPO_RX_PARITY_EN
        cyc(1'b1, 1'b1);
        push_frame(4'b1001, 1'b1, 1'b0, 0);
        run(1, 1'b1);
        chk("p_good_valid", 8'(v0), 8'd1);
        cyc(1'b1, 1'b1);
        push_frame(4'b1001, 1'b1, 1'b1, 0);
        run(1, 1'b1);
        chk("p_bad_perr", 8'(p0), 8'd1);
        chk("p_bad_valid", 8'(v0), 8'd0);
`endif
        for (int k = 0; k < 60; k++) begin
            push_frame(4'($urandom), $urandom_range(0, 4) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 2));
            repeat ($urandom_range(0, 2)) push(1'b1, 1'b0, 2'd0, 4'h0);
            while (q.size() > 0) cyc(1'($urandom_range(0, 1)), $urandom_range(0, 2) != 0);
        end
        repeat (3) cyc(1'b1, 1'b1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
